// File: rtl/pong_game_ctrl_if.sv
// Scan/button inputs and game-state outputs shared by the pong controller and its consumers.
interface pong_game_ctrl_if;
  logic [7:0] scan_x;
  logic [5:0] scan_y;
  logic       btn_left;
  logic       btn_right;
  logic       btn_serve;
  logic       frame_tick;
  logic [7:0] paddle_x;
  logic [7:0] ball_x;
  logic [5:0] ball_y;
  logic [7:0] score;
  logic [1:0] lives;
  logic [1:0] state;

  // The game controller consumes scan/buttons and publishes game state.
  modport slave (
    input  scan_x, scan_y, btn_left, btn_right, btn_serve,
    output frame_tick, paddle_x, ball_x, ball_y, score, lives, state
  );

  // The video/input side drives scan/buttons and observes game state.
  modport master (
    output scan_x, scan_y, btn_left, btn_right, btn_serve,
    input  frame_tick, paddle_x, ball_x, ball_y, score, lives, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: derives a frame tick from the scan position and steps
// paddle, ball, score and lives once every FRAME_DIV frames.
module pong_game_ctrl #(
  parameter int unsigned SCREEN_W   = 96,
  parameter int unsigned SCREEN_H   = 64,
  parameter int unsigned PADDLE_W   = 16,
  parameter int unsigned PADDLE_H   = 4,
  parameter int unsigned BALL_R     = 2,
  parameter int unsigned FRAME_DIV  = 2,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned MISS_STEPS = 8,
  parameter int unsigned SERVE_X    = 20,
  parameter int unsigned SERVE_Y    = 20
) (
  input  logic             clk,
  input  logic             rst,
  pong_game_ctrl_if.slave  io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [7:0] PADDLE_HOME = 8'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [8:0] PADDLE_MAX  = 9'(SCREEN_W - PADDLE_W);
  localparam logic [7:0] SERVE_X8    = 8'(SERVE_X);
  localparam logic [5:0] SERVE_Y6    = 6'(SERVE_Y);
  localparam logic [1:0] LIVES2      = 2'(LIVES);
  localparam logic [8:0] BALL_R9     = 9'(BALL_R);
  localparam logic [6:0] BALL_R7     = 7'(BALL_R);
  localparam logic [8:0] X_LAST      = 9'(SCREEN_W - 1);
  localparam logic [6:0] Y_FLOOR     = 7'(SCREEN_H - PADDLE_H - 1);
  localparam logic [8:0] HIT_REACH   = 9'(PADDLE_W - 1 + BALL_R);
  localparam logic [7:0] FRAME_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [7:0] MISS_LAST   = 8'(MISS_STEPS - 1);

  state_e     state_q,      state_d;
  logic       frame_tick_q, frame_tick_d;
  logic [7:0] prev_x_q,     prev_x_d;
  logic [5:0] prev_y_q,     prev_y_d;
  logic [7:0] frame_cnt_q,  frame_cnt_d;
  logic [7:0] miss_cnt_q,   miss_cnt_d;
  logic [7:0] paddle_x_q,   paddle_x_d;
  logic [7:0] ball_x_q,     ball_x_d;
  logic [5:0] ball_y_q,     ball_y_d;
  logic       vx_neg_q,     vx_neg_d;
  logic       vy_neg_q,     vy_neg_d;
  logic [7:0] score_q,      score_d;
  logic [1:0] lives_q,      lives_d;

  logic       step;
  logic [8:0] px9, bx9;
  logic [6:0] by7;
  logic [7:0] paddle_mv;
  logic [7:0] bx_next;
  logic       vx_neg_next;
  logic [5:0] by_next;
  logic       vy_neg_next;
  logic       y_floor;
  logic       hit;

  assign px9  = {1'b0, paddle_x_q};
  assign bx9  = {1'b0, ball_x_q};
  assign by7  = {1'b0, ball_y_q};
  assign step = frame_tick_q && (frame_cnt_q == FRAME_LAST);

  // Paddle candidate position from the buttons, clamped to the screen.
  always_comb begin
    paddle_mv = paddle_x_q;
    if (io.btn_left && !io.btn_right && (paddle_x_q != 8'd0)) begin
      paddle_mv = 8'(px9 - 9'd1);
    end else if (io.btn_right && !io.btn_left && (px9 < PADDLE_MAX)) begin
      paddle_mv = 8'(px9 + 9'd1);
    end
  end

  // Horizontal ball motion with side-wall bounce.
  always_comb begin
    bx_next     = ball_x_q;
    vx_neg_next = vx_neg_q;
    if (!vx_neg_q && ((bx9 + BALL_R9) == X_LAST)) begin
      vx_neg_next = 1'b1;
      bx_next     = 8'(bx9 - 9'd1);
    end else if (vx_neg_q && (bx9 == BALL_R9)) begin
      vx_neg_next = 1'b0;
      bx_next     = 8'(bx9 + 9'd1);
    end else if (vx_neg_q) begin
      bx_next     = 8'(bx9 - 9'd1);
    end else begin
      bx_next     = 8'(bx9 + 9'd1);
    end
  end

  // Vertical ball motion: top bounce, paddle-row hit detection.
  always_comb begin
    by_next     = ball_y_q;
    vy_neg_next = vy_neg_q;
    y_floor     = !vy_neg_q && ((by7 + BALL_R7) == Y_FLOOR);
    hit         = ((bx9 + BALL_R9) >= px9) && (bx9 <= (px9 + HIT_REACH));
    if (vy_neg_q && (by7 == BALL_R7)) begin
      vy_neg_next = 1'b0;
      by_next     = 6'(by7 + 7'd1);
    end else if (y_floor) begin
      vy_neg_next = 1'b1;
      by_next     = 6'(by7 - 7'd1);
    end else if (vy_neg_q) begin
      by_next     = 6'(by7 - 7'd1);
    end else begin
      by_next     = 6'(by7 + 7'd1);
    end
  end

  // Frame tick detection, frame divider and game state machine.
  always_comb begin
    state_d      = state_q;
    prev_x_d     = io.scan_x;
    prev_y_d     = io.scan_y;
    frame_tick_d = ((prev_x_q != 8'd0) || (prev_y_q != 6'd0)) &&
                   (io.scan_x == 8'd0) && (io.scan_y == 6'd0);
    frame_cnt_d  = frame_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    paddle_x_d   = paddle_x_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    vx_neg_d     = vx_neg_q;
    vy_neg_d     = vy_neg_q;
    score_d      = score_q;
    lives_d      = lives_q;

    if (frame_tick_q) begin
      frame_cnt_d = step ? 8'd0 : 8'(frame_cnt_q + 8'd1);
    end

    if (step) begin
      unique case (state_q)
        ST_IDLE: begin
          paddle_x_d = paddle_mv;
          ball_x_d   = SERVE_X8;
          ball_y_d   = SERVE_Y6;
          vx_neg_d   = 1'b0;
          vy_neg_d   = 1'b1;
          if (io.btn_serve) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          paddle_x_d = paddle_mv;
          if (y_floor && !hit) begin
            lives_d    = 2'(lives_q - 2'd1);
            miss_cnt_d = 8'd0;
            state_d    = ST_MISS;
          end else begin
            ball_x_d = bx_next;
            vx_neg_d = vx_neg_next;
            ball_y_d = by_next;
            vy_neg_d = vy_neg_next;
            if (y_floor && (score_q != 8'hFF)) score_d = 8'(score_q + 8'd1);
          end
        end
        ST_MISS: begin
          if (miss_cnt_q == MISS_LAST) begin
            miss_cnt_d = 8'd0;
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d  = ST_IDLE;
              ball_x_d = SERVE_X8;
              ball_y_d = SERVE_Y6;
              vx_neg_d = 1'b0;
              vy_neg_d = 1'b1;
            end
          end else begin
            miss_cnt_d = 8'(miss_cnt_q + 8'd1);
          end
        end
        ST_OVER: begin
          if (io.btn_serve) begin
            state_d    = ST_IDLE;
            lives_d    = LIVES2;
            score_d    = 8'd0;
            paddle_x_d = PADDLE_HOME;
            ball_x_d   = SERVE_X8;
            ball_y_d   = SERVE_Y6;
            vx_neg_d   = 1'b0;
            vy_neg_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_tick_q <= 1'b0;
      prev_x_q     <= 8'd0;
      prev_y_q     <= 6'd0;
      frame_cnt_q  <= 8'd0;
      miss_cnt_q   <= 8'd0;
      paddle_x_q   <= PADDLE_HOME;
      ball_x_q     <= SERVE_X8;
      ball_y_q     <= SERVE_Y6;
      vx_neg_q     <= 1'b0;
      vy_neg_q     <= 1'b1;
      score_q      <= 8'd0;
      lives_q      <= LIVES2;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= frame_tick_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      frame_cnt_q  <= frame_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      paddle_x_q   <= paddle_x_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      vx_neg_q     <= vx_neg_d;
      vy_neg_q     <= vy_neg_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
    end
  end

  assign io.frame_tick = frame_tick_q;
  assign io.paddle_x   = paddle_x_q;
  assign io.ball_x     = ball_x_q;
  assign io.ball_y     = ball_y_q;
  assign io.score      = score_q;
  assign io.lives      = lives_q;
  assign io.state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized bench for pong_game_ctrl against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int W = 96, H = 64, PW = 16, PH = 4, R = 2;
  localparam int FD = 2, LV = 3, MS = 8, SX = 20, SY = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus ();
  pong_game_ctrl dut (.clk(clk), .rst(rst), .io(bus));

  int total = 0;
  int bad   = 0;
  int tick_seen = 0;

  // Reference model state (plain integers, signed velocities)
  int m_state, m_px, m_bx, m_by, m_vx, m_vy, m_score, m_lives;
  int m_fcnt, m_mcnt, m_tick, m_prevx, m_prevy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int move_paddle(int px, bit l, bit r);
    if (l && !r) return (px > 0) ? px - 1 : px;
    if (r && !l) return (px < W - PW) ? px + 1 : px;
    return px;
  endfunction

  task automatic serve_ball();
    m_bx = SX; m_by = SY; m_vx = 1; m_vy = -1;
  endtask

  task automatic model_reset();
    m_state = 0; m_px = (W - PW) / 2; serve_ball();
    m_score = 0; m_lives = LV; m_fcnt = 0; m_mcnt = 0;
    m_tick = 0; m_prevx = 0; m_prevy = 0;
  endtask

  // One physics step of the game, from the rules written as arithmetic
  task automatic model_step(bit l, bit r, bit srv);
    int npx, nbx, nby, nvx, nvy;
    case (m_state)
      0: begin
        m_px = move_paddle(m_px, l, r);
        serve_ball();
        if (srv) m_state = 1;
      end
      1: begin
        npx = move_paddle(m_px, l, r);
        nvx = m_vx; nvy = m_vy;
        if (m_vx > 0 && m_bx + R == W - 1) begin nvx = -1; nbx = m_bx - 1; end
        else if (m_vx < 0 && m_bx == R)    begin nvx = 1;  nbx = m_bx + 1; end
        else nbx = m_bx + m_vx;
        if (m_vy < 0 && m_by == R) begin nvy = 1; nby = m_by + 1; end
        else if (m_vy > 0 && m_by + R == H - PH - 1) begin
          if (m_bx + R >= m_px && m_bx - R <= m_px + PW - 1) begin
            nvy = -1; nby = m_by - 1;
            if (m_score < 255) m_score++;
          end else begin
            m_lives--; m_mcnt = 0; m_state = 2;
            nbx = m_bx; nby = m_by; nvx = m_vx; nvy = m_vy;
          end
        end else nby = m_by + m_vy;
        m_px = npx; m_bx = nbx; m_by = nby; m_vx = nvx; m_vy = nvy;
      end
      2: begin
        if (m_mcnt == MS - 1) begin
          m_mcnt = 0;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 0; serve_ball(); end
        end else m_mcnt++;
      end
      default: begin
        if (srv) begin
          m_state = 0; m_lives = LV; m_score = 0; m_px = (W - PW) / 2; serve_ball();
        end
      end
    endcase
  endtask

  // Advance one clock: update the model with the inputs applied, then compare
  task automatic cyc();
    int sx, sy;
    bit nt;
    @(posedge clk);
    sx = int'(bus.scan_x); sy = int'(bus.scan_y);
    if (rst) model_reset();
    else begin
      if (m_tick == 1 && m_fcnt == FD - 1) model_step(bus.btn_left, bus.btn_right, bus.btn_serve);
      if (m_tick == 1) m_fcnt = (m_fcnt == FD - 1) ? 0 : m_fcnt + 1;
      nt = (m_prevx != 0 || m_prevy != 0) && sx == 0 && sy == 0;
      m_prevx = sx; m_prevy = sy; m_tick = int'(nt);
    end
    #1;
    if (bus.frame_tick === 1'b1) tick_seen++;
    chk("frame_tick", 32'(bus.frame_tick), 32'(m_tick));
    chk("state",      32'(bus.state),      32'(m_state));
    chk("paddle_x",   32'(bus.paddle_x),   32'(m_px));
    chk("ball_x",     32'(bus.ball_x),     32'(m_bx));
    chk("ball_y",     32'(bus.ball_y),     32'(m_by));
    chk("score",      32'(bus.score),      32'(m_score));
    chk("lives",      32'(bus.lives),      32'(m_lives));
  endtask

  // One frame: a few non-origin scan cycles, then the origin held 2-3 cycles
  task automatic run_frame(bit l, bit r, bit srv, bit do_rst);
    int n, z;
    bus.btn_left = l; bus.btn_right = r; bus.btn_serve = srv;
    n = $urandom_range(1, 3);
    z = $urandom_range(2, 3);
    for (int i = 0; i < n; i++) begin
      bus.scan_x = 8'($urandom_range(1, W - 1));
      bus.scan_y = 6'($urandom_range(0, H - 1));
      cyc();
    end
    bus.scan_x = 8'd0; bus.scan_y = 6'd0;
    for (int i = 0; i < z; i++) begin
      rst = do_rst && (i == 0);
      cyc();
    end
    rst = 1'b0;
  endtask

  task automatic run_step(bit l, bit r, bit srv);
    run_frame(l, r, srv, 1'b0);
    run_frame(l, r, srv, 1'b0);
  endtask

  initial begin
    bit l, r, srv, rr;
    model_reset();
    rst = 1'b1;
    bus.scan_x = 8'd0; bus.scan_y = 6'd0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_serve = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    chk("rst_state",  32'(bus.state), 32'd0);
    chk("rst_paddle", 32'(bus.paddle_x), 32'd40);
    chk("rst_ball",   {16'(bus.ball_x), 16'(bus.ball_y)}, {16'd20, 16'd20});
    chk("rst_score",  32'(bus.score), 32'd0);
    chk("rst_lives",  32'(bus.lives), 32'd3);
    chk("rst_tick",   32'(bus.frame_tick), 32'd0);

    tick_seen = 0;
    repeat (10) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ten_frames_ticks", 32'(tick_seen), 32'd10);
    chk("ten_frames_idle",  32'(bus.state), 32'd0);

    run_step(1'b0, 1'b0, 1'b1);
    chk("serve_play", 32'(bus.state), 32'd1);
    chk("serve_ball", {16'(bus.ball_x), 16'(bus.ball_y)}, {16'd20, 16'd20});
    run_step(1'b0, 1'b0, 1'b0);
    chk("first_move", {16'(bus.ball_x), 16'(bus.ball_y)}, {16'd21, 16'd19});

    // Reset lands exactly on the cycle a frame tick would have been produced
    bus.scan_x = 8'd5; bus.scan_y = 6'd3;
    cyc();
    bus.scan_x = 8'd0; bus.scan_y = 6'd0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_tick",  32'(bus.frame_tick), 32'd0);
    chk("midrst_state", 32'(bus.state), 32'd0);
    chk("midrst_ball",  {16'(bus.ball_x), 16'(bus.ball_y)}, {16'd20, 16'd20});
    cyc();
    chk("midrst_no_late_tick", 32'(bus.frame_tick), 32'd0);

    // Paddle clamps at both walls and holds with both buttons
    repeat (45) run_step(1'b1, 1'b0, 1'b0);
    chk("paddle_left_wall", 32'(bus.paddle_x), 32'd0);
    repeat (85) run_step(1'b0, 1'b1, 1'b0);
    chk("paddle_right_wall", 32'(bus.paddle_x), 32'd80);
    repeat (3) run_step(1'b1, 1'b1, 1'b0);
    chk("paddle_both_hold", 32'(bus.paddle_x), 32'd80);

    // Random play: paddle mostly tracks the ball so both hits and misses occur
    repeat (3000) begin
      if ($urandom_range(0, 99) < 60) begin
        l = (m_bx < m_px + PW / 2 - 3);
        r = (m_bx > m_px + PW / 2 + 3);
      end else begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      srv = ($urandom_range(0, 9) < 3);
      rr  = ($urandom_range(0, 599) == 0);
      run_frame(l, r, srv, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
